// File: rtl/spi_frame_rx.sv
// SPI slave front end: synchronises the raw SPI pins into clk, deserialises
// 10-bit {op[1:0], data[7:0]} frames (MSB first) into a small FWFT FIFO,
// shifts a readback byte out on miso during bits 2..9, and flags frames whose
// bit count is not exactly 10.
//
// Consumer handshake: frame_valid means the FIFO head (frame_op/frame_data)
// is meaningful; a pop happens on every cycle with frame_valid && frame_ready.
// Head data holds steady while frame_valid && !frame_ready.
module spi_frame_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_AW     = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               sck,
  input  logic               ssel,
  input  logic               mosi,
  output logic               miso,
  output logic               rd_req,
  input  logic [7:0]         rd_data,
  output logic               frame_valid,
  output logic [1:0]         frame_op,
  output logic [7:0]         frame_data,
  input  logic               frame_ready,
  output logic               frame_err,
  output logic               overflow,
  input  logic               clr_overflow,
  output logic [FIFO_AW:0]   fifo_count,
  output logic [1:0]         dbg_state_o
);

  localparam int DEPTH = 1 << FIFO_AW;

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    ACTIVE    = 2'd2
  } state_e;

  logic [SYNC_STAGES-1:0] sck_sync_q, ssel_sync_q, mosi_sync_q;
  logic                   sck_prev_q, ssel_prev_q;
  logic                   sck_s, ssel_s, mosi_s;
  logic                   sck_rise, ss_fall, ss_rise;

  state_e      state_q, state_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [9:0]  sr_q, sr_d;
  logic        miso_q, miso_d;
  logic        rd_req_q, rd_req_d;
  logic        rd_dly_q;
  logic [7:0]  shadow_q;
  logic        eval_q, eval_d;
  logic [3:0]  cnt_inc;
  logic [3:0]  rb_sel;

  logic [9:0]         mem_q [DEPTH];
  logic [FIFO_AW-1:0] wptr_q, rptr_q;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               overflow_q;
  logic               push, pop, full, push_ok;

  assign sck_s  = sck_sync_q[SYNC_STAGES-1];
  assign ssel_s = ssel_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  assign sck_rise = sck_s & ~sck_prev_q;
  assign ss_fall  = ~ssel_s & ssel_prev_q;
  assign ss_rise  = ssel_s & ~ssel_prev_q;

  // Pin synchronisers plus one extra sample of sck/ssel for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sck_sync_q  <= '0;
      ssel_sync_q <= '0;
      mosi_sync_q <= '0;
      sck_prev_q  <= 1'b0;
      ssel_prev_q <= 1'b0;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck};
      ssel_sync_q <= {ssel_sync_q[SYNC_STAGES-2:0], ssel};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      sck_prev_q  <= sck_s;
      ssel_prev_q <= ssel_s;
    end
  end

  // FSM state and frame datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= WAIT_IDLE;
      bit_cnt_q <= 4'd0;
      sr_q      <= 10'd0;
      miso_q    <= 1'b0;
      rd_req_q  <= 1'b0;
      rd_dly_q  <= 1'b0;
      shadow_q  <= 8'd0;
      eval_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      sr_q      <= sr_d;
      miso_q    <= miso_d;
      rd_req_q  <= rd_req_d;
      rd_dly_q  <= rd_req_q;
      eval_q    <= eval_d;
      if (rd_dly_q) shadow_q <= rd_data;
    end
  end

  assign cnt_inc = (bit_cnt_q == 4'd15) ? 4'd15 : bit_cnt_q + 4'd1;
  assign rb_sel  = 4'd9 - cnt_inc;

  // Next-state logic: frame start/end detection, bit shifting, readback bit.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    sr_d      = sr_q;
    miso_d    = miso_q;
    rd_req_d  = 1'b0;
    eval_d    = 1'b0;
    case (state_q)
      WAIT_IDLE: begin
        miso_d = 1'b0;
        if (ssel_s) state_d = IDLE;
      end
      IDLE: begin
        miso_d = 1'b0;
        if (ss_fall) begin
          state_d   = ACTIVE;
          rd_req_d  = 1'b1;
          bit_cnt_d = 4'd0;
          sr_d      = 10'd0;
        end
      end
      ACTIVE: begin
        if (sck_rise) begin
          sr_d      = {sr_q[8:0], mosi_s};
          bit_cnt_d = cnt_inc;
          if (cnt_inc >= 4'd2 && cnt_inc <= 4'd9) miso_d = shadow_q[rb_sel[2:0]];
          else                                    miso_d = 1'b0;
        end
        if (ss_rise) begin
          state_d = IDLE;
          eval_d  = 1'b1;
        end
      end
      default: state_d = WAIT_IDLE;
    endcase
  end

  // Frame evaluation happens the cycle after ss_rise, when bit_cnt/sr are final.
  assign push      = eval_q && (bit_cnt_q == 4'd10);
  assign frame_err = eval_q && (bit_cnt_q != 4'd10);

  assign full    = (count_q == (FIFO_AW+1)'(DEPTH));
  assign pop     = frame_valid && frame_ready;
  assign push_ok = push && (!full || pop);

  // FIFO storage; no reset needed since the head is only meaningful when valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= sr_q;
  end

  // Occupancy next value from accepted push and pop.
  always_comb begin
    count_d = count_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // FIFO pointers, occupancy and the sticky overflow flag (set beats clear).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop)     rptr_q <= rptr_q + 1'b1;
      count_q <= count_d;
      if (push && full && !pop) overflow_q <= 1'b1;
      else if (clr_overflow)    overflow_q <= 1'b0;
    end
  end

  assign frame_valid = (count_q != '0);
  assign frame_op    = mem_q[rptr_q][9:8];
  assign frame_data  = mem_q[rptr_q][7:0];
  assign fifo_count  = count_q;
  assign overflow    = overflow_q;
  assign miso        = miso_q;
  assign rd_req      = rd_req_q;
  assign dbg_state_o = state_q;

endmodule
